// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and load scoreboard for the 8-entry register file.
// Optional feature macro: RF_WB_BYPASS_EN (in-flight write bypass outputs).
module regfile_wb_arbiter #(
  parameter int BITS  = 8,
  parameter int RBITS = 3,
  parameter int NREG  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_alu_valid,
  input  logic [RBITS-1:0] i_alu_rd,
  input  logic [BITS-1:0]  i_alu_data,
  output logic             o_alu_ready,
  input  logic             i_ld_issue,
  input  logic [RBITS-1:0] i_ld_issue_rd,
  input  logic             i_ld_valid,
  input  logic [RBITS-1:0] i_ld_rd,
  input  logic [BITS-1:0]  i_ld_data,
  output logic             o_ld_ready,
  input  logic [RBITS-1:0] i_rs1,
  input  logic [RBITS-1:0] i_rs2,
  output logic             o_stall,
  output logic [NREG-1:0]  o_pending,
  output logic             o_rf_we,
  output logic [RBITS-1:0] o_rf_rd,
  output logic [BITS-1:0]  o_rf_din
`ifdef RF_WB_BYPASS_EN
  ,
  output logic             o_byp1_hit,
  output logic             o_byp2_hit,
  output logic [BITS-1:0]  o_byp_data
`endif
);

  logic             r_rf_we;
  logic [RBITS-1:0] r_rf_rd;
  logic [BITS-1:0]  r_rf_din;
  logic [NREG-1:0]  r_pending;
  logic             r_last_grant;   // 0 = ALU, 1 = load

  logic             w_en;
  logic             w_gnt_ld;
  logic             w_gnt_alu;
  logic             w_ld_acc;
  logic             w_alu_acc;
  logic [NREG-1:0]  w_pending_nxt;
  logic [RBITS-1:0] w_rs2_eff;
  logic             w_pend1;
  logic             w_pend2;
  logic             w_fly1;
  logic             w_fly2;

  assign w_en      = i_rst_n & i_run;
  assign w_gnt_ld  = i_ld_valid & (~i_alu_valid | ~r_last_grant);
  assign w_gnt_alu = i_alu_valid & ~w_gnt_ld;
  assign w_ld_acc  = w_en & w_gnt_ld;
  assign w_alu_acc = w_en & w_gnt_alu;

  assign o_ld_ready  = w_ld_acc;
  assign o_alu_ready = w_alu_acc;

  // Set beats clear when issue and write-back hit the same register.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ld_acc)
      w_pending_nxt[i_ld_rd] = 1'b0;
    if (w_en && i_ld_issue)
      w_pending_nxt[i_ld_issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rf_we      <= 1'b0;
      r_rf_rd      <= '0;
      r_rf_din     <= '0;
      r_pending    <= '0;
      r_last_grant <= 1'b0;
    end else begin
      r_rf_we   <= 1'b0;
      r_pending <= w_pending_nxt;
      if (w_ld_acc) begin
        r_rf_we      <= (i_ld_rd != '0);
        r_rf_rd      <= i_ld_rd;
        r_rf_din     <= i_ld_data;
        r_last_grant <= 1'b1;
      end else if (w_alu_acc) begin
        r_rf_we      <= (i_alu_rd != '0);
        r_rf_rd      <= i_alu_rd;
        r_rf_din     <= i_alu_data;
        r_last_grant <= 1'b0;
      end
    end
  end

  // Read port 2 only reaches r0..r3, so only its low two index bits matter.
  assign w_rs2_eff = {{(RBITS-2){1'b0}}, i_rs2[1:0]};

  assign w_pend1 = r_pending[i_rs1];
  assign w_pend2 = r_pending[w_rs2_eff];
  assign w_fly1  = r_rf_we && (r_rf_rd == i_rs1) && (i_rs1 != '0);
  assign w_fly2  = r_rf_we && (r_rf_rd == w_rs2_eff) && (w_rs2_eff != '0);

`ifdef RF_WB_BYPASS_EN
  assign o_byp1_hit = w_fly1;
  assign o_byp2_hit = w_fly2;
  assign o_byp_data = r_rf_din;
  assign o_stall    = w_pend1 | w_pend2;
`else
  assign o_stall    = w_pend1 | w_pend2 | w_fly1 | w_fly2;
`endif

  assign o_pending = r_pending;
  assign o_rf_we   = r_rf_we;
  assign o_rf_rd   = r_rf_rd;
  assign o_rf_din  = r_rf_din;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, run;
  logic       alu_valid, ld_issue, ld_valid;
  logic [2:0] alu_rd, ld_issue_rd, ld_rd, rs1, rs2;
  logic [7:0] alu_data, ld_data;
  logic       alu_ready, ld_ready, stall, rf_we;
  logic [7:0] pending, rf_din;
  logic [2:0] rf_rd;
  int         n_chk = 0;
  int         n_err = 0;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
  logic       byp1_hit, byp2_hit;
  logic [7:0] byp_data;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_ld_issue(ld_issue), .i_ld_issue_rd(ld_issue_rd),
    .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .i_rs1(rs1), .i_rs2(rs2), .o_stall(stall), .o_pending(pending),
    .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_din(rf_din)
`ifdef RF_WB_BYPASS_EN
    , .o_byp1_hit(byp1_hit), .o_byp2_hit(byp2_hit), .o_byp_data(byp_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; ld_issue = 0;
  endtask

  // Clock edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_rd [3] = '{3'd2, 3'd1, 3'd2};
    int exp_dt [3] = '{8'h22, 8'h11, 8'h22};
    bit exp_ld [3] = '{1'b1, 1'b0, 1'b1};

    rst_n = 0; run = 1; idle();
    alu_rd = 0; alu_data = 0; ld_issue_rd = 0; ld_rd = 0; ld_data = 0; rs1 = 0; rs2 = 0;
    alu_valid = 1; alu_rd = 3'd3; alu_data = 8'h5A;
    tick(); tick();
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_din", rf_din, 0);
    chk("rst_pending", pending, 0);

    // ALU write rd=3, then in-flight hazard on rs1=3
    rst_n = 1; #1;
    chk("alu3_ready", alu_ready, 1);
    chk("alu3_ld_ready", ld_ready, 0);
    tick();
    idle(); rs1 = 3'd3; #1;
    chk("alu3_we", rf_we, 1);
    chk("alu3_rd", rf_rd, 3);
    chk("alu3_din", rf_din, 8'h5A);
    chk("alu3_stall", stall, !BYP);
`ifdef RF_WB_BYPASS_EN
    chk("alu3_byp1", byp1_hit, 1);
    chk("alu3_bypdata", byp_data, 8'h5A);
`endif
    tick();
    chk("hold_we", rf_we, 0);
    chk("hold_rd", rf_rd, 3);
    chk("hold_din", rf_din, 8'h5A);
    chk("hold_stall", stall, 0);
    rs1 = 0;

    // Round-robin: last grant was ALU, so load first
    alu_valid = 1; alu_rd = 3'd1; alu_data = 8'h11;
    ld_valid = 1; ld_rd = 3'd2; ld_data = 8'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rr_ld_ready", ld_ready, exp_ld[k]);
      chk("rr_alu_ready", alu_ready, !exp_ld[k]);
      tick();
      chk("rr_we", rf_we, 1);
      chk("rr_rd", rf_rd, exp_rd[k]);
      chk("rr_din", rf_din, exp_dt[k]);
    end
    idle();

    // Load to r5 pending until write-back
    ld_issue = 1; ld_issue_rd = 3'd5;
    tick();
    idle(); rs1 = 3'd5; #1;
    chk("ld5_pending", pending, 8'h20);
    chk("ld5_stall", stall, 1);
    tick();
    chk("ld5_stall_hold", stall, 1);
    ld_valid = 1; ld_rd = 3'd5; ld_data = 8'h77; #1;
    chk("ld5_ready", ld_ready, 1);
    tick();
    idle(); #1;
    chk("ld5_clr", pending, 0);
    chk("ld5_we", rf_we, 1);
    chk("ld5_rd", rf_rd, 5);
    chk("ld5_din", rf_din, 8'h77);
    chk("ld5_fly_stall", stall, !BYP);
    tick();
    chk("ld5_nostall", stall, 0);
    rs1 = 0;

    // rd=0 write accepted but discarded
    alu_valid = 1; alu_rd = 3'd0; alu_data = 8'hFF; #1;
    chk("r0_ready", alu_ready, 1);
    tick();
    idle(); #1;
    chk("r0_we", rf_we, 0);
    chk("r0_din", rf_din, 8'hFF);
    chk("r0_pending", pending, 0);
    chk("r0_stall", stall, 0);

    // rs2=6 aliases to r2
    ld_issue = 1; ld_issue_rd = 3'd2;
    tick();
    idle(); rs2 = 3'd6; #1;
    chk("rs2_alias_pend", pending, 8'h04);
    chk("rs2_alias_stall", stall, 1);
    rs2 = 3'd4; #1;
    chk("rs2_alias_r0", stall, 0);
    rs2 = 0;
    ld_valid = 1; ld_rd = 3'd2; ld_data = 8'h02;
    tick();
    idle(); #1;
    chk("r2_clr", pending, 0);

    // Issue and write-back to r4 in the same cycle: set wins
    ld_issue = 1; ld_issue_rd = 3'd4;
    tick();
    ld_valid = 1; ld_rd = 3'd4; ld_data = 8'h44; #1;
    chk("setwin_ready", ld_ready, 1);
    tick();
    idle(); #1;
    chk("setwin_pend", pending, 8'h10);
    chk("setwin_we", rf_we, 1);
    ld_valid = 1; ld_rd = 3'd4;
    tick();
    idle(); #1;
    chk("r4_clr", pending, 0);

    // run low: nothing accepted, scoreboard holds
    run = 0;
    alu_valid = 1; alu_rd = 3'd1; ld_valid = 1; ld_rd = 3'd2; ld_issue = 1; ld_issue_rd = 3'd3; #1;
    chk("norun_alu_ready", alu_ready, 0);
    chk("norun_ld_ready", ld_ready, 0);
    tick();
    chk("norun_we", rf_we, 0);
    chk("norun_pend", pending, 0);
    idle(); run = 1;

    // Load write in flight plus pending bit, then reset
    ld_valid = 1; ld_rd = 3'd7; ld_data = 8'h3C; ld_issue = 1; ld_issue_rd = 3'd6;
    tick();
    chk("pre_rst_we", rf_we, 1);
    chk("pre_rst_pend", pending, 8'h40);
    idle();
    rst_n = 0; alu_valid = 1; alu_rd = 3'd1; #1;
    chk("inrst_alu_ready", alu_ready, 0);
    tick();
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_rd", rf_rd, 0);
    chk("post_rst_din", rf_din, 0);
    chk("post_rst_pend", pending, 0);
    rst_n = 1;
    ld_valid = 1; ld_rd = 3'd2; #1;
    chk("post_rst_tie_ld", ld_ready, 1);
    chk("post_rst_tie_alu", alu_ready, 0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
